// File: rtl/eq_pkg.sv
// eq_pkg: shared types, coefficient-select constants and arithmetic helpers
// for the time-multiplexed biquad equaliser (eq_chain_tdm / eq_mac).
package eq_pkg;

   // Sequencer states of the equaliser.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_WB   = 2'd2,
      S_OUT  = 2'd3
   } state_t;

   // Coefficient slots inside one band; also the MAC tap order.
   localparam int SEL_B0 = 0;
   localparam int SEL_B1 = 1;
   localparam int SEL_B2 = 2;
   localparam int SEL_A1 = 3;
   localparam int SEL_A2 = 4;
   localparam int N_TAPS = 5;

   // Working width of the helper functions; wide enough for the guarded
   // accumulator at any sensible parameter set.
   localparam int SAT_W = 128;

   // 1.0 in a Q(q) fixed-point format.
   function automatic logic signed [SAT_W-1:0] coef_unity(input int q);
      logic signed [SAT_W-1:0] r;
      r    = '0;
      r[q] = 1'b1;
      return r;
   endfunction

   // Clamp a signed value to the range of a signed 'width'-bit number.
   function automatic logic signed [SAT_W-1:0] saturate(
      input logic signed [SAT_W-1:0] value,
      input int                      width
   );
      logic signed [SAT_W-1:0] one;
      logic signed [SAT_W-1:0] max_v;
      logic signed [SAT_W-1:0] min_v;
      one    = '0;
      one[0] = 1'b1;
      max_v  = (one <<< (width - 1)) - one;
      min_v  = ~max_v;
      if (value > max_v)      return max_v;
      else if (value < min_v) return min_v;
      else                    return value;
   endfunction

endpackage

// File: rtl/eq_mac.sv
// eq_mac: signed multiply-accumulate shared by every band and channel.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_en         : add (or subtract) i_coef*i_sig into the accumulator
//   i_clr        : with i_en, start a fresh sum with this product
//   i_sub        : subtract the product instead of adding it
//   i_coef/i_sig : Q_FP signed operands
//   o_y          : accumulator >>> Q_FP, saturated to ACC_W (combinational)
module eq_mac
   import eq_pkg::*;
#(
   parameter int COEF_W = 32,
   parameter int ACC_W  = 32,
   parameter int Q_FP   = 15
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_en,
   input  logic                     i_clr,
   input  logic                     i_sub,
   input  logic signed [COEF_W-1:0] i_coef,
   input  logic signed [ACC_W-1:0]  i_sig,
   output logic signed [ACC_W-1:0]  o_y
);

   localparam int PROD_W = COEF_W + ACC_W;
   // Three guard bits cover the sum of five full-scale products.
   localparam int MACC_W = PROD_W + 3;

   logic signed [PROD_W-1:0] w_prod;
   logic signed [MACC_W-1:0] w_addend;
   logic signed [MACC_W-1:0] w_base;
   logic signed [MACC_W-1:0] r_acc;

   assign w_prod   = PROD_W'(i_coef) * PROD_W'(i_sig);
   assign w_addend = i_sub ? -MACC_W'(w_prod) : MACC_W'(w_prod);
   assign w_base   = i_clr ? '0 : r_acc;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_acc <= '0;
      end else if (i_en) begin
         r_acc <= w_base + w_addend;
      end else if (i_clr) begin
         r_acc <= '0;
      end
   end

   assign o_y = ACC_W'(saturate(SAT_W'(r_acc >>> Q_FP), ACC_W));

endmodule

// File: rtl/eq_chain_tdm.sv
// eq_chain_tdm: N_CH-channel cascade of N_BANDS Direct-Form-I biquads
// evaluated on one shared MAC (5 tap cycles + 1 write-back per band).
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_valid/o_ready/i_data : input frame handshake, channel c at [c*DATA_W +: DATA_W]
//   o_valid/i_ready/o_data : output frame handshake, same packing
//   i_bypass              : per-band bypass mask, captured with the frame
//   i_cfg_*               : shadow coefficient write and commit to active set
module eq_chain_tdm
   import eq_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int Q_FP    = 15,
   parameter int ACC_W   = 32,
   parameter int COEF_W  = 32,
   parameter int N_BANDS = 6,
   parameter int N_CH    = 2,
   localparam int BAND_W = (N_BANDS > 1) ? $clog2(N_BANDS) : 1
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic                     i_valid,
   output logic                     o_ready,
   input  logic [N_CH*DATA_W-1:0]   i_data,
   output logic                     o_valid,
   input  logic                     i_ready,
   output logic [N_CH*DATA_W-1:0]   o_data,
   input  logic [N_BANDS-1:0]       i_bypass,
   input  logic                     i_cfg_we,
   input  logic [BAND_W-1:0]        i_cfg_band,
   input  logic [2:0]               i_cfg_sel,
   input  logic [COEF_W-1:0]        i_cfg_data,
   input  logic                     i_cfg_commit
);

   localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam logic signed [COEF_W-1:0] COEF_ONE = COEF_W'(coef_unity(Q_FP));

   state_t                   r_state, w_state_nxt;
   logic [CH_W-1:0]          r_ch;
   logic [BAND_W-1:0]        r_band;
   logic [2:0]               r_tap;
   logic [N_BANDS-1:0]       r_bypass;
   logic                     r_pending;
   logic                     r_valid;
   logic [N_CH*DATA_W-1:0]   r_data;

   // Per channel: the signal entering the current band (ends as final y).
   logic signed [ACC_W-1:0]  r_sig [N_CH];
   logic signed [ACC_W-1:0]  r_x1  [N_CH][N_BANDS];
   logic signed [ACC_W-1:0]  r_x2  [N_CH][N_BANDS];
   logic signed [ACC_W-1:0]  r_y1  [N_CH][N_BANDS];
   logic signed [ACC_W-1:0]  r_y2  [N_CH][N_BANDS];
   logic signed [COEF_W-1:0] r_shadow [N_BANDS][N_TAPS];
   logic signed [COEF_W-1:0] r_active [N_BANDS][N_TAPS];

   logic                     w_last_band;
   logic                     w_last_ch;
   logic                     w_release;
   logic                     w_copy;
   logic                     w_cfg_ok;
   logic signed [ACC_W-1:0]  w_x;
   logic signed [ACC_W-1:0]  w_y;
   logic signed [ACC_W-1:0]  w_y_mac;
   logic signed [COEF_W-1:0] w_coef;
   logic signed [ACC_W-1:0]  w_opnd;
   logic                     w_sub;

   assign w_last_band = (r_band == BAND_W'(N_BANDS - 1));
   assign w_last_ch   = (r_ch == CH_W'(N_CH - 1));
   assign w_release   = (r_state == S_OUT) && i_ready;
   // Immediate copy only when idle with no frame being accepted; otherwise
   // the commit waits so the in-flight frame sees a single coefficient set.
   assign w_copy      = (i_cfg_commit && (r_state == S_IDLE) && !i_valid) ||
                        (w_release && (r_pending || i_cfg_commit));
   assign w_cfg_ok    = i_cfg_we && (int'(i_cfg_band) < N_BANDS) &&
                        (i_cfg_sel <= 3'(SEL_A2));

   assign w_x     = r_sig[r_ch];
   assign w_y     = r_bypass[r_band] ? w_x : w_y_mac;
   assign o_valid = r_valid;
   assign o_data  = r_data;

   // Next state and handshake output.
   always_comb begin
      w_state_nxt = r_state;
      o_ready     = 1'b0;
      case (r_state)
         S_IDLE: begin
            o_ready = 1'b1;
            if (i_valid) w_state_nxt = S_MAC;
         end
         S_MAC:   if (r_tap == 3'(N_TAPS - 1)) w_state_nxt = S_WB;
         S_WB:    if (w_last_band && w_last_ch) w_state_nxt = S_OUT;
                  else w_state_nxt = S_MAC;
         S_OUT:   if (i_ready) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Tap operand select; feedback taps subtract because a1/a2 enter as -a*y.
   always_comb begin
      w_coef = r_active[r_band][SEL_B0];
      w_opnd = w_x;
      w_sub  = 1'b0;
      case (r_tap)
         3'd1: begin w_coef = r_active[r_band][SEL_B1]; w_opnd = r_x1[r_ch][r_band]; end
         3'd2: begin w_coef = r_active[r_band][SEL_B2]; w_opnd = r_x2[r_ch][r_band]; end
         3'd3: begin w_coef = r_active[r_band][SEL_A1]; w_opnd = r_y1[r_ch][r_band]; w_sub = 1'b1; end
         3'd4: begin w_coef = r_active[r_band][SEL_A2]; w_opnd = r_y2[r_ch][r_band]; w_sub = 1'b1; end
         default: ;
      endcase
   end

   eq_mac #(
      .COEF_W (COEF_W),
      .ACC_W  (ACC_W),
      .Q_FP   (Q_FP)
   ) u_mac (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_en   (r_state == S_MAC),
      .i_clr  (r_tap == 3'd0),
      .i_sub  (w_sub),
      .i_coef (w_coef),
      .i_sig  (w_opnd),
      .o_y    (w_y_mac)
   );

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state   <= S_IDLE;
         r_ch      <= '0;
         r_band    <= '0;
         r_tap     <= '0;
         r_bypass  <= '0;
         r_pending <= 1'b0;
         r_valid   <= 1'b0;
         r_data    <= '0;
         // NOTE: these arrays are reset explicitly because the filter must
         // restart from zero state and identity coefficients; that forces
         // them into flops rather than RAM, which is fine at this size.
         for (int c = 0; c < N_CH; c++) begin
            r_sig[c] <= '0;
            for (int b = 0; b < N_BANDS; b++) begin
               r_x1[c][b] <= '0;
               r_x2[c][b] <= '0;
               r_y1[c][b] <= '0;
               r_y2[c][b] <= '0;
            end
         end
         for (int b = 0; b < N_BANDS; b++) begin
            for (int t = 0; t < N_TAPS; t++) begin
               r_shadow[b][t] <= (t == SEL_B0) ? COEF_ONE : '0;
               r_active[b][t] <= (t == SEL_B0) ? COEF_ONE : '0;
            end
         end
      end else begin
         r_state <= w_state_nxt;

         case (r_state)
            S_IDLE: begin
               if (i_valid) begin
                  for (int c = 0; c < N_CH; c++) begin
                     r_sig[c] <= ACC_W'($signed(i_data[c*DATA_W +: DATA_W])) <<< Q_FP;
                  end
                  r_bypass <= i_bypass;
                  r_ch     <= '0;
                  r_band   <= '0;
                  r_tap    <= '0;
               end
            end
            S_MAC: begin
               r_tap <= (r_tap == 3'(N_TAPS - 1)) ? 3'd0 : r_tap + 3'd1;
            end
            S_WB: begin
               r_sig[r_ch] <= w_y;
               if (r_bypass[r_band]) begin
                  r_x1[r_ch][r_band] <= '0;
                  r_x2[r_ch][r_band] <= '0;
                  r_y1[r_ch][r_band] <= '0;
                  r_y2[r_ch][r_band] <= '0;
               end else begin
                  r_x2[r_ch][r_band] <= r_x1[r_ch][r_band];
                  r_x1[r_ch][r_band] <= w_x;
                  r_y2[r_ch][r_band] <= r_y1[r_ch][r_band];
                  r_y1[r_ch][r_band] <= w_y;
               end
               if (w_last_band) begin
                  r_data[int'(r_ch)*DATA_W +: DATA_W] <=
                     DATA_W'(saturate(SAT_W'(w_y >>> Q_FP), DATA_W));
                  r_band <= '0;
                  if (w_last_ch) r_valid <= 1'b1;
                  else           r_ch    <= r_ch + 1'b1;
               end else begin
                  r_band <= r_band + 1'b1;
               end
            end
            S_OUT: begin
               if (i_ready) r_valid <= 1'b0;
            end
            default: ;
         endcase

         // Copy reads the pre-write shadow, so a same-cycle write is kept
         // in the shadow only.
         if (w_copy) begin
            for (int b = 0; b < N_BANDS; b++) begin
               for (int t = 0; t < N_TAPS; t++) begin
                  r_active[b][t] <= r_shadow[b][t];
               end
            end
         end
         if (w_cfg_ok) begin
            r_shadow[i_cfg_band][i_cfg_sel] <= i_cfg_data;
         end

         if (w_copy)            r_pending <= 1'b0;
         else if (i_cfg_commit) r_pending <= 1'b1;
      end
   end

endmodule

// File: tb/tb_eq_chain_tdm.sv
// tb_eq_chain_tdm: directed self-checking bench for eq_chain_tdm at default
// parameters (2 channels, 6 bands, Q15). Inputs change 1 time unit after the
// rising edge; outputs are sampled there too.
module tb_eq_chain_tdm;

   logic        clk = 1'b0;
   logic        i_rst;
   logic        i_valid;
   logic        o_ready;
   logic [31:0] i_data;
   logic        o_valid;
   logic        i_ready;
   logic [31:0] o_data;
   logic [5:0]  i_bypass;
   logic        i_cfg_we;
   logic [2:0]  i_cfg_band;
   logic [2:0]  i_cfg_sel;
   logic [31:0] i_cfg_data;
   logic        i_cfg_commit;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   eq_chain_tdm dut (
      .i_clk        (clk),
      .i_rst        (i_rst),
      .i_valid      (i_valid),
      .o_ready      (o_ready),
      .i_data       (i_data),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_data       (o_data),
      .i_bypass     (i_bypass),
      .i_cfg_we     (i_cfg_we),
      .i_cfg_band   (i_cfg_band),
      .i_cfg_sel    (i_cfg_sel),
      .i_cfg_data   (i_cfg_data),
      .i_cfg_commit (i_cfg_commit)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      i_rst = 1'b1;
      tick();
      tick();
      i_rst = 1'b0;
   endtask

   task automatic set_coef(input int band, input int sel, input logic [31:0] val);
      i_cfg_we   = 1'b1;
      i_cfg_band = 3'(band);
      i_cfg_sel  = 3'(sel);
      i_cfg_data = val;
      tick();
      i_cfg_we   = 1'b0;
   endtask

   task automatic commit();
      i_cfg_commit = 1'b1;
      tick();
      i_cfg_commit = 1'b0;
   endtask

   // Offer one frame, wait (bounded) for o_valid. Optionally pulse commit or
   // reset at a given cycle after accept. lat = cycles from accept edge to
   // o_valid (200 if it never came); rhi = cycles with o_ready high meanwhile.
   task automatic run_frame(input logic [15:0] d0, input logic [15:0] d1,
                            input logic [5:0] byp, input int commit_at,
                            input int rst_at, output logic [15:0] q0,
                            output logic [15:0] q1, output int lat,
                            output int rhi);
      i_data   = {d1, d0};
      i_bypass = byp;
      i_valid  = 1'b1;
      tick();
      i_valid  = 1'b0;
      lat      = 0;
      rhi      = 0;
      while (!o_valid && lat < 200) begin
         i_cfg_commit = (lat == commit_at);
         i_rst        = (lat == rst_at);
         tick();
         lat++;
         if (o_ready && !o_valid) rhi++;
      end
      i_cfg_commit = 1'b0;
      i_rst        = 1'b0;
      q0 = o_data[15:0];
      q1 = o_data[31:16];
      if (i_ready) tick();
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", o_valid); end
      checks++; if (o_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 00000000", o_data); end
      checks++; if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b expected 1", o_ready); end
   endtask

   task automatic test_identity();
      logic [15:0] q0, q1;
      int lat, rhi;
      run_frame(16'h1234, 16'hFEDC, 6'b0, -1, -1, q0, q1, lat, rhi);
      checks++; if (q0 !== 16'h1234) begin errors++; $display("FAIL ident_ch0: got %h expected 1234", q0); end
      checks++; if (q1 !== 16'hFEDC) begin errors++; $display("FAIL ident_ch1: got %h expected fedc", q1); end
      checks++; if (lat != 72) begin errors++; $display("FAIL latency: got %0d expected 72", lat); end
      checks++; if (rhi != 0) begin errors++; $display("FAIL ready_busy: got %0d cycles high expected 0", rhi); end
      checks++; if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
         errors++; $display("FAIL ident_release: got ready=%b valid=%b expected 1/0", o_ready, o_valid);
      end
   endtask

   task automatic test_gain_saturation();
      logic [15:0] din [3]  = '{16'h3000, 16'h5000, 16'hB000};
      logic [15:0] dexp [3] = '{16'h6000, 16'h7FFF, 16'h8000};
      logic [15:0] q0, q1;
      int lat, rhi;
      do_reset();
      set_coef(0, 0, 32'h0001_0000);
      commit();
      for (int k = 0; k < 3; k++) begin
         run_frame(din[k], 16'h0000, 6'b0, -1, -1, q0, q1, lat, rhi);
         checks++; if (q0 !== dexp[k]) begin errors++; $display("FAIL gain_ch0[%0d]: got %h expected %h", k, q0, dexp[k]); end
         checks++; if (q1 !== 16'h0) begin errors++; $display("FAIL gain_ch1[%0d]: got %h expected 0000", k, q1); end
      end
   endtask

   task automatic test_recursion();
      logic [15:0] din [4]  = '{16'h4000, 16'h0000, 16'h0000, 16'h0000};
      logic [15:0] dexp [4] = '{16'h4000, 16'h2000, 16'h1000, 16'h0800};
      logic [15:0] q0, q1;
      int lat, rhi;
      do_reset();
      set_coef(0, 0, 32'h0000_8000);
      set_coef(0, 3, 32'hFFFF_C000);
      commit();
      for (int k = 0; k < 4; k++) begin
         run_frame(din[k], 16'h0000, 6'b0, -1, -1, q0, q1, lat, rhi);
         checks++; if (q0 !== dexp[k]) begin errors++; $display("FAIL recur_ch0[%0d]: got %h expected %h", k, q0, dexp[k]); end
         checks++; if (q1 !== 16'h0) begin errors++; $display("FAIL recur_ch1[%0d]: got %h expected 0000", k, q1); end
      end
   endtask

   task automatic test_backpressure();
      logic [15:0] q0, q1;
      int lat, rhi, vcnt;
      do_reset();
      i_ready = 1'b0;
      run_frame(16'h0111, 16'h0222, 6'b0, -1, -1, q0, q1, lat, rhi);
      checks++; if ({q1, q0} !== 32'h0222_0111) begin errors++; $display("FAIL bp_data: got %h expected 02220111", {q1, q0}); end
      for (int k = 0; k < 10; k++) begin
         i_valid = (k == 4);
         i_data  = 32'h7777_7777;
         tick();
         checks++; if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_data !== 32'h0222_0111) begin
            errors++;
            $display("FAIL bp_hold[%0d]: got valid=%b ready=%b data=%h expected 1/0/02220111", k, o_valid, o_ready, o_data);
         end
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      tick();
      checks++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release: got valid=%b ready=%b expected 0/1", o_valid, o_ready);
      end
      vcnt = 0;
      for (int k = 0; k < 80; k++) begin
         tick();
         if (o_valid) vcnt++;
      end
      checks++; if (vcnt != 0) begin errors++; $display("FAIL bp_ignored: got %0d valid cycles expected 0", vcnt); end
   endtask

   task automatic test_commit();
      logic [15:0] q0, q1;
      int lat, rhi;
      // Deferred commit mid-frame.
      do_reset();
      set_coef(2, 0, 32'h0000_4000);
      run_frame(16'h2000, 16'h0000, 6'b0, 20, -1, q0, q1, lat, rhi);
      checks++; if (q0 !== 16'h2000) begin errors++; $display("FAIL defer_cur: got %h expected 2000", q0); end
      run_frame(16'h2000, 16'h0000, 6'b0, -1, -1, q0, q1, lat, rhi);
      checks++; if (q0 !== 16'h1000) begin errors++; $display("FAIL defer_next: got %h expected 1000", q0); end
      // Write and commit in the same idle cycle: commit takes the old shadow.
      do_reset();
      i_cfg_we     = 1'b1;
      i_cfg_band   = 3'd0;
      i_cfg_sel    = 3'd0;
      i_cfg_data   = 32'h0001_0000;
      i_cfg_commit = 1'b1;
      tick();
      i_cfg_we     = 1'b0;
      i_cfg_commit = 1'b0;
      run_frame(16'h1000, 16'h0000, 6'b0, -1, -1, q0, q1, lat, rhi);
      checks++; if (q0 !== 16'h1000) begin errors++; $display("FAIL wecommit_old: got %h expected 1000", q0); end
      commit();
      run_frame(16'h1000, 16'h0000, 6'b0, -1, -1, q0, q1, lat, rhi);
      checks++; if (q0 !== 16'h2000) begin errors++; $display("FAIL wecommit_new: got %h expected 2000", q0); end
   endtask

   task automatic test_bypass_reset();
      logic [15:0] q0, q1;
      int lat, rhi;
      do_reset();
      set_coef(0, 0, 32'h0001_0000);
      commit();
      run_frame(16'h1234, 16'h0100, 6'b000001, -1, -1, q0, q1, lat, rhi);
      checks++; if ({q1, q0} !== 32'h0100_1234) begin errors++; $display("FAIL bypass: got %h expected 01001234", {q1, q0}); end
      run_frame(16'h1234, 16'h0100, 6'b000000, -1, -1, q0, q1, lat, rhi);
      checks++; if ({q1, q0} !== 32'h0200_2468) begin errors++; $display("FAIL no_bypass: got %h expected 02002468", {q1, q0}); end
      // Reset 30 cycles into a frame: it must never complete.
      run_frame(16'h4000, 16'h4000, 6'b0, -1, 30, q0, q1, lat, rhi);
      checks++; if (lat != 200) begin errors++; $display("FAIL rst_drop: got o_valid after %0d cycles expected none", lat); end
      checks++; if (o_ready !== 1'b1 || o_data !== 32'h0) begin
         errors++; $display("FAIL rst_state: got ready=%b data=%h expected 1/00000000", o_ready, o_data);
      end
      // Feedback on band 0 exposes any y1 left over from the dropped frame.
      set_coef(0, 3, 32'hFFFF_C000);
      commit();
      run_frame(16'h0000, 16'h0000, 6'b0, -1, -1, q0, q1, lat, rhi);
      checks++; if ({q1, q0} !== 32'h0) begin errors++; $display("FAIL rst_hist: got %h expected 00000000", {q1, q0}); end
   endtask

   initial begin
      i_rst        = 1'b1;
      i_valid      = 1'b0;
      i_data       = '0;
      i_ready      = 1'b1;
      i_bypass     = '0;
      i_cfg_we     = 1'b0;
      i_cfg_band   = '0;
      i_cfg_sel    = '0;
      i_cfg_data   = '0;
      i_cfg_commit = 1'b0;

      test_reset();
      test_identity();
      test_gain_saturation();
      test_recursion();
      test_backpressure();
      test_commit();
      test_bypass_reset();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
